bus_select_decoder_5_32: RTL

- Inverse of the datapath bus-source encoder: takes a 5-bit bus source code and drives the matching one-hot output-enable line onto the 32-line drive-enable field.
- Lines 15:0 are general register outputs (R0out..R15out); lines 31:16 are special-source outputs.
- Registered with break-before-make sequencing, so two sources never drive the shared bus in the same cycle.
- Sits between the control unit and the register/special-register tri-state enables.

---
 rtl/bus_select_decoder_5_32_pkg.sv | 54 +++++
 rtl/bus_select_decoder_5_32_onehot.sv | 19 +
 rtl/bus_select_decoder_5_32.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bus_select_decoder_5_32_pkg.sv
// Shared definitions for the datapath bus-source select path: source codes,
// decoder state encoding and the legal-code lookup.
package cpu_bus_pkg;

    localparam int CODE_W = 5;
    localparam int EN_W   = 32;

    typedef logic [CODE_W-1:0] bus_code_t;

    localparam bus_code_t CODE_R0     = 5'h00;
    localparam bus_code_t CODE_R1     = 5'h01;
    localparam bus_code_t CODE_R2     = 5'h02;
    localparam bus_code_t CODE_R3     = 5'h03;
    localparam bus_code_t CODE_R4     = 5'h04;
    localparam bus_code_t CODE_R5     = 5'h05;
    localparam bus_code_t CODE_R6     = 5'h06;
    localparam bus_code_t CODE_R7     = 5'h07;
    localparam bus_code_t CODE_R8     = 5'h08;
    localparam bus_code_t CODE_R9     = 5'h09;
    localparam bus_code_t CODE_R10    = 5'h0A;
    localparam bus_code_t CODE_R11    = 5'h0B;
    localparam bus_code_t CODE_R12    = 5'h0C;
    localparam bus_code_t CODE_R13    = 5'h0D;
    localparam bus_code_t CODE_R14    = 5'h0E;
    localparam bus_code_t CODE_R15    = 5'h0F;
    localparam bus_code_t CODE_HI     = 5'h10;
    localparam bus_code_t CODE_LO     = 5'h11;
    localparam bus_code_t CODE_ZHI    = 5'h12;
    localparam bus_code_t CODE_ZLO    = 5'h13;
    localparam bus_code_t CODE_PC     = 5'h15;
    localparam bus_code_t CODE_MDR    = 5'h16;
    localparam bus_code_t CODE_INPORT = 5'h17;
    localparam bus_code_t CODE_C      = 5'h19;
    localparam bus_code_t CODE_SPARE  = 5'h1A;

    // One bit per code; a set bit means that code has a drive-enable line.
    // Reserved: 0x14, 0x18, 0x1B..0x1F.
    localparam logic [EN_W-1:0] LEGAL_MASK =
        (32'h1 << CODE_HI)  | (32'h1 << CODE_LO)  | (32'h1 << CODE_ZHI) |
        (32'h1 << CODE_ZLO) | (32'h1 << CODE_PC)  | (32'h1 << CODE_MDR) |
        (32'h1 << CODE_INPORT) | (32'h1 << CODE_C) | (32'h1 << CODE_SPARE) |
        32'h0000_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    function automatic logic is_legal_code(input bus_code_t code);
        return LEGAL_MASK[code];
    endfunction

endpackage

// File: rtl/bus_select_decoder_5_32_onehot.sv
// Combinational 5-bit bus source code to 32-line one-hot decode.
// Reserved codes produce an all-zero field with legal=0.
module bus_select_onehot (
    input  logic [4:0]  code,
    output logic [31:0] onehot,
    output logic        legal
);
    import cpu_bus_pkg::*;

    // Decode code to its enable line, suppressing reserved codes.
    always_comb begin
        legal  = is_legal_code(code);
        onehot = '0;
        if (legal) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_select_decoder_5_32.sv
// Registered bus source select with break-before-make turnaround.
// The drop-bus input is named bus_release because "release" is a reserved
// word in SystemVerilog.
//
//  state | meaning
//  IDLE  | no source driving, requests accepted
//  DRIVE | one source enabled (active_code), requests accepted
//  TURN  | all enables low for TURN_CYCLES before the pending source drives
module bus_select_decoder_5_32 #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  code,
    input  logic        code_valid,
    input  logic        bus_release,
    output logic [31:0] drive_en,
    output logic [4:0]  active_code,
    output logic        drive_active,
    output logic        code_ready,
    output logic        bad_code
);
    import cpu_bus_pkg::*;

    localparam logic [2:0] TURN_LOAD = 3'(TURN_CYCLES);

    state_t      state;
    logic [4:0]  pend_code;
    logic [2:0]  turn_cnt;
    logic [4:0]  dec_code;
    logic [31:0] dec_onehot;
    logic        dec_legal;

    // One shared decoder: the pending code is decoded while turning, the
    // incoming request otherwise (requests are not accepted during TURN).
    assign dec_code   = (state == TURN) ? pend_code : code;
    assign code_ready = (state != TURN);

    bus_select_onehot u_onehot (
        .code   (dec_code),
        .onehot (dec_onehot),
        .legal  (dec_legal)
    );

    // Sequencing FSM with registered enable outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= IDLE;
            drive_en     <= '0;
            active_code  <= '0;
            drive_active <= 1'b0;
            bad_code     <= 1'b0;
            pend_code    <= '0;
            turn_cnt     <= '0;
        end else begin
            bad_code <= 1'b0;
            case (state)
                IDLE: begin
                    if (code_valid) begin
                        if (dec_legal) begin
                            state        <= DRIVE;
                            drive_en     <= dec_onehot;
                            drive_active <= 1'b1;
                            active_code  <= code;
                        end else begin
                            bad_code <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    // A request takes priority over a simultaneous release.
                    if (code_valid) begin
                        if (!dec_legal) begin
                            bad_code <= 1'b1;
                        end else if (code != active_code) begin
                            if (TURN_CYCLES == 0) begin
                                drive_en    <= dec_onehot;
                                active_code <= code;
                            end else begin
                                state        <= TURN;
                                drive_en     <= '0;
                                drive_active <= 1'b0;
                                active_code  <= '0;
                                pend_code    <= code;
                                turn_cnt     <= TURN_LOAD;
                            end
                        end
                    end else if (bus_release) begin
                        state        <= IDLE;
                        drive_en     <= '0;
                        drive_active <= 1'b0;
                        active_code  <= '0;
                    end
                end
                TURN: begin
                    if (bus_release) begin
                        state     <= IDLE;
                        pend_code <= '0;
                        turn_cnt  <= '0;
                    end else if (turn_cnt == 3'd1) begin
                        state        <= DRIVE;
                        drive_en     <= dec_onehot;
                        drive_active <= 1'b1;
                        active_code  <= pend_code;
                        turn_cnt     <= '0;
                    end else begin
                        turn_cnt <= turn_cnt - 3'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    drive_en     <= '0;
                    drive_active <= 1'b0;
                    active_code  <= '0;
                    pend_code    <= '0;
                    turn_cnt     <= '0;
                end
            endcase
        end
    end

endmodule
